instr_fetch: RTL and testbench

Instruction fetch unit: the initiator side of the word-indexed, combinational-read instruction memory. It holds the program counter and drives the memory address every cycle. It captures the returned instruction word together with its PC into a 2-entry prefetch buffer and presents them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and reload the PC.

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared widths, increments and the prefetch-buffer entry layout for the
// instruction fetch unit.
package instr_fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PC_INCR          = 32'd4;
    localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetch slot: the byte PC travels with its instruction word.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous prefetch FIFO. Slot 0 is always the head; a pop
// shifts slot 1 down, and a push lands in the first free slot after any pop.
// Flush empties the buffer. Storage is cleared on reset.
module fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [ENTRY_WIDTH-1:0] wdata_i,
    output logic [ENTRY_WIDTH-1:0] rdata_o,
    output logic [1:0]             count_o
);

    logic [ENTRY_WIDTH-1:0] slot0_q, slot0_d;
    logic [ENTRY_WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]             count_q, count_d;
    logic [1:0]             wr_idx;

    assign wr_idx  = count_q - {1'b0, pop_i};
    assign rdata_o = slot0_q;
    assign count_o = count_q;

    // Next-state for slots and occupancy: pop shifts, push fills behind it.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (pop_i) begin
                slot0_d = slot1_q;
            end
            if (push_i) begin
                if (wr_idx == 2'd0) begin
                    slot0_d = wdata_i;
                end else begin
                    slot1_d = wdata_i;
                end
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Storage and occupancy registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction
// memory every cycle and feeds decode through a 2-entry prefetch buffer.
// Redirects flush the buffer and reload the PC.
// Optional feature macro IFETCH_ALIGN_CHECK_EN: misaligned redirect targets
// raise a sticky o_fetch_fault and halt fetch until an aligned redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [ADDR_WIDTH-1:0]  o_imem_address,
    input  logic [INSTR_WIDTH-1:0] i_imem_instruction,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    input  logic                   i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic                   o_fetch_fault
`endif
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            count;
    logic                  pop;
    logic                  push;
    logic                  fault;
    fetch_entry_t          head;
    fetch_entry_t          wentry;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign fault         = fault_q;
    assign o_fetch_fault = fault_q;

    // Fault tracks the alignment of the most recent redirect target.
    always_comb begin
        fault_d = fault_q;
        if (i_redirect_valid) begin
            fault_d = |i_redirect_pc[1:0];
        end
    end

    // Sticky fault register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign fault = 1'b0;
`endif

    assign o_imem_address = {2'b00, pc_q[ADDR_WIDTH-1:2]};
    assign o_valid        = (count != 2'd0);
    assign pop            = o_valid & i_ready;
    assign push           = !i_redirect_valid & !fault
                          & ((count < 2'(FIFO_DEPTH)) | pop);
    assign wentry         = '{pc: pc_q, instr: i_imem_instruction};
    assign o_pc           = head.pc;
    assign o_instruction  = head.instr;

    // PC advance: redirect wins, otherwise step past each captured word.
    always_comb begin
        pc_d = pc_q;
        if (i_redirect_valid) begin
            pc_d = i_redirect_pc & ~32'h0000_0003;
        end else if (push) begin
            pc_d = pc_q + PC_INCR;
        end
    end

    // PC register; reset overrides any redirect in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (i_redirect_valid),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a queue-based reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ready, redir;
    logic [31:0] rpc;
    logic [31:0] addr, imem, instr, pc;
    logic        valid;

    logic        rst_w;
    logic [31:0] addr_w, imem_w, instr_w, pc_w;
    logic        valid_w;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fault, fault_w;
`endif

    assign imem   = 32'h1000_0000 + addr;
    assign imem_w = 32'h1000_0000 + addr_w;

    instr_fetch dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .o_imem_address     (addr),
        .i_imem_instruction (imem),
        .o_valid            (valid),
        .i_ready            (ready),
        .o_instruction      (instr),
        .o_pc               (pc),
        .i_redirect_valid   (redir),
        .i_redirect_pc      (rpc)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .o_fetch_fault      (fault)
`endif
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .i_clk              (clk),
        .i_rst              (rst_w),
        .o_imem_address     (addr_w),
        .i_imem_instruction (imem_w),
        .o_valid            (valid_w),
        .i_ready            (1'b1),
        .o_instruction      (instr_w),
        .o_pc               (pc_w),
        .i_redirect_valid   (1'b0),
        .i_redirect_pc      (32'h0)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .o_fetch_fault      (fault_w)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural PC, queue of {pc, instr}, fault flag.
    logic [31:0] m_pc = 32'h0;
    logic [63:0] m_q[$];
    bit          m_fault = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
        return 32'h1000_0000 + (byte_pc >> 2);
    endfunction

    task automatic tick();
        bit pop, push;
        int n;
        n = m_q.size();
        if (rst) begin
            m_q.delete();
            m_pc = 32'h0;
            m_fault = 1'b0;
        end else begin
            pop  = (n > 0) && ready;
            push = !redir && !m_fault && ((n < 2) || pop);
            if (pop) void'(m_q.pop_front());
            if (redir) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
`ifdef IFETCH_ALIGN_CHECK_EN
                m_fault = (rpc[1:0] != 2'b00);
`endif
            end else if (push) begin
                m_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; ready = 0; redir = 0; rpc = 0; rst_w = 1;
        tick(); tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", valid); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", addr); end
        checks++; if (addr_w !== 32'h3FFF_FFFE) begin errors++; $display("FAIL reset_addr_w got %h want 3ffffffe", addr_w); end
`ifdef IFETCH_ALIGN_CHECK_EN
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %h want 0", fault); end
`endif
    endtask

    task automatic test_stream();
        rst = 0; ready = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %h want 1", i, valid); end
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, pc, 32'(4 * i)); end
            checks++; if (instr !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, instr, 32'h1000_0000 + 32'(i)); end
            checks++; if (addr !== 32'(i + 1)) begin errors++; $display("FAIL stream_addr[%0d] got %h want %h", i, addr, 32'(i + 1)); end
        end
    endtask

    task automatic test_stall();
        rst = 1; tick(); rst = 0; ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d] got valid %h pc %h want 1 0", i, valid, pc); end
        end
        checks++; if (addr !== 32'd2) begin errors++; $display("FAIL stall_addr got %h want 2", addr); end
        ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (valid !== 1'b1 || pc !== 32'(4 * i)) begin errors++; $display("FAIL stall_release[%0d] got valid %h pc %h want 1 %h", i, valid, pc, 32'(4 * i)); end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        rst = 1; tick(); rst = 0; ready = 0;
        tick(); tick();
        ready = 1; redir = 1; rpc = 32'h0000_0100;
        checks++; if (valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL redir_head got valid %h pc %h want 1 0", valid, pc); end
        tick();
        redir = 0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %h want 0", valid); end
        checks++; if (addr !== 32'h40) begin errors++; $display("FAIL redir_addr got %h want 40", addr); end
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL redir_target got valid %h pc %h want 1 100", valid, pc); end
        checks++; if (instr !== 32'h1000_0040) begin errors++; $display("FAIL redir_instr got %h want 10000040", instr); end
        tick();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL redir_next got %h want 104", pc); end
    endtask

    task automatic test_wrap();
        rst_w = 0;
        tick();
        checks++; if (valid_w !== 1'b1 || pc_w !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap0 got valid %h pc %h want 1 fffffff8", valid_w, pc_w); end
        tick();
        checks++; if (pc_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap1 got %h want fffffffc", pc_w); end
        tick();
        checks++; if (pc_w !== 32'h0) begin errors++; $display("FAIL wrap2 got %h want 0", pc_w); end
        checks++; if (instr_w !== 32'h1000_0000) begin errors++; $display("FAIL wrap2_instr got %h want 10000000", instr_w); end
    endtask

    task automatic test_align();
        rst = 1; tick(); rst = 0; ready = 1;
        tick(); tick();
        redir = 1; rpc = 32'h0000_0102;
        tick();
        redir = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            checks++; if (fault !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL align_fault[%0d] got fault %h valid %h want 1 0", i, fault, valid); end
            tick();
        end
        redir = 1; rpc = 32'h0000_0200;
        tick();
        redir = 0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL align_clear got %h want 0", fault); end
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h200) begin errors++; $display("FAIL align_resume got valid %h pc %h want 1 200", valid, pc); end
`else
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL align_flush got %h want 0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL align_trunc got valid %h pc %h want 1 100", valid, pc); end
`endif
    endtask

    task automatic test_reset_redirect();
        rst = 1; tick(); rst = 0; ready = 0;
        tick(); tick();
        rst = 1; redir = 1; rpc = 32'h0000_0300;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstredir_valid got %h want 0", valid); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL rstredir_addr got %h want 0", addr); end
        rst = 0; redir = 0; ready = 1;
        tick();
        checks++; if (valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL rstredir_pc got valid %h pc %h want 1 0", valid, pc); end
    endtask

    task automatic test_random();
        logic [63:0] head;
        rst = 1; redir = 0; tick(); rst = 0;
        for (int i = 0; i < 600; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            rst   = ($urandom_range(0, 99) == 0);
            tick();
            checks++; if (valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d] got %h want %h", i, valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                head = m_q[0];
                checks++; if (pc !== head[63:32]) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, pc, head[63:32]); end
                checks++; if (instr !== head[31:0]) begin errors++; $display("FAIL rand_instr[%0d] got %h want %h", i, instr, head[31:0]); end
            end
            checks++; if (addr !== {2'b00, m_pc[31:2]}) begin errors++; $display("FAIL rand_addr[%0d] got %h want %h", i, addr, {2'b00, m_pc[31:2]}); end
`ifdef IFETCH_ALIGN_CHECK_EN
            checks++; if (fault !== m_fault) begin errors++; $display("FAIL rand_fault[%0d] got %h want %h", i, fault, m_fault); end
`endif
        end
        rst = 0; redir = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_align();
        test_reset_redirect();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
